// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Two-master (instruction fetch / data load-store) arbiter in  |
// |               front of the DRAM controller user port. One op in flight,    |
// |               level requests, 1-cycle acks, registered controller outputs. |
// | Options     : ARB_ROUND_ROBIN_EN - alternate grants on simultaneous        |
// |               requests; undefined = data port has fixed priority.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter logic [2:0] IFETCH_CTRL = 3'b010
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        i_ir_req,
  input  logic [31:0] i_ir_addr,
  output logic [31:0] o_ir_data,
  output logic        o_ir_ack,
  input  logic        i_dr_req,
  input  logic        i_dr_we,
  input  logic [31:0] i_dr_addr,
  input  logic [31:0] i_dr_wdata,
  input  logic [2:0]  i_dr_ctrl,
  output logic [31:0] o_dr_rdata,
  output logic        o_dr_ack,
  output logic        o_mem_rd_en,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_ctrl,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_busy,
  input  logic        i_mem_ready,
  output logic [2:0]  o_arb_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4
  } state_t;

  state_t state;
  logic   grant_data;  // owner of the op in flight: 1 = data port, 0 = fetch port
  logic   op_we;       // op in flight is a store
  logic   start;       // an op can be launched from IDLE this cycle
  logic   pick_data;   // data port wins the IDLE arbitration

  assign start = i_mem_ready && !i_mem_busy && (i_ir_req || i_dr_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_was_data;

  // On a tie the port that did not win last time gets the grant
  assign pick_data = i_dr_req && (!i_ir_req || !last_was_data);

  // Grant history, updated on every launch; reset treats fetch as last winner
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      last_was_data <= 1'b0;
    end else if (state == IDLE && start) begin
      last_was_data <= pick_data;
    end
  end
`else
  // Fixed priority: the data port always wins a tie
  assign pick_data = i_dr_req;
`endif

  assign o_arb_state = state;

  // Arbitration FSM; every controller-facing and master-facing output is registered here
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state       <= IDLE;
      grant_data  <= 1'b0;
      op_we       <= 1'b0;
      o_ir_data   <= '0;
      o_ir_ack    <= 1'b0;
      o_dr_rdata  <= '0;
      o_dr_ack    <= 1'b0;
      o_mem_rd_en <= 1'b0;
      o_mem_wr_en <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_ctrl  <= '0;
    end else begin
      o_ir_ack <= 1'b0;
      o_dr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            grant_data <= pick_data;
            if (pick_data) begin
              op_we       <= i_dr_we;
              o_mem_addr  <= i_dr_addr;
              o_mem_wdata <= i_dr_wdata;
              o_mem_ctrl  <= i_dr_ctrl;
              o_mem_rd_en <= !i_dr_we;
              o_mem_wr_en <= i_dr_we;
            end else begin
              op_we       <= 1'b0;
              o_mem_addr  <= i_ir_addr;
              o_mem_wdata <= '0;
              o_mem_ctrl  <= IFETCH_CTRL;
              o_mem_rd_en <= 1'b1;
              o_mem_wr_en <= 1'b0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Controller has taken the command once it reports busy
          if (i_mem_busy) begin
            o_mem_rd_en <= 1'b0;
            o_mem_wr_en <= 1'b0;
            state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!i_mem_busy) begin
            if (!op_we) begin
              if (grant_data) o_dr_rdata <= i_mem_rdata;
              else            o_ir_data  <= i_mem_rdata;
            end
            if (grant_data) o_dr_ack <= 1'b1;
            else            o_ir_ack <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          o_mem_rd_en <= 1'b0;
          o_mem_wr_en <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
